// File: rtl/aes_word_bridge_pkg.sv
// Shared constants and FSM state type for the AES word-serial bridge.
// Package is named aes_pkg so integrating levels can share it with top_aes.
package aes_pkg;

  localparam int unsigned AES_LEN       = 128;
  localparam int unsigned WORD_W        = 32;
  localparam int unsigned WORDS_PER_BLK = 4;
  localparam int unsigned CNT_W         = $clog2(WORDS_PER_BLK);

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    DRAIN = 2'd3
  } state_t;

endpackage

// File: rtl/aes_word_bridge_if.sv
// Word-stream interface of the AES bridge: input words with key address, output result words.
// slave = bridge side, master = upstream producer / downstream consumer side.
interface aes_word_bridge_if #(
  parameter int unsigned WORD_W     = aes_pkg::WORD_W,
  parameter int unsigned ADDR_WIDTH = 5
);

  logic                  in_valid;
  logic                  in_ready;
  logic [WORD_W-1:0]     in_data;
  logic [ADDR_WIDTH-1:0] in_key_addr;
  logic                  out_valid;
  logic                  out_ready;
  logic [WORD_W-1:0]     out_data;

  modport slave (
    input  in_valid,
    input  in_data,
    input  in_key_addr,
    output in_ready,
    output out_valid,
    output out_data,
    input  out_ready
  );

  modport master (
    output in_valid,
    output in_data,
    output in_key_addr,
    input  in_ready,
    input  out_valid,
    input  out_data,
    output out_ready
  );

endinterface

// File: rtl/aes_word_bridge.sv
// Packs four input words into a 128-bit block for top_aes, starts it, then streams the result out.
// Optional WAIT watchdog enabled by defining AES_BRIDGE_TIMEOUT_EN.
module aes_word_bridge #(
  parameter int unsigned AES_LEN        = aes_pkg::AES_LEN,
  parameter int unsigned WORD_W         = aes_pkg::WORD_W,
  parameter int unsigned ADDR_WIDTH     = 5,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  nrst,
  aes_word_bridge_if.slave      bus,
  output logic                  aes_start,
  output logic [ADDR_WIDTH-1:0] aes_key_addr,
  output logic [AES_LEN-1:0]    aes_plaintext,
  input  logic [AES_LEN-1:0]    aes_result,
  input  logic                  aes_done,
  output logic                  busy,
  output logic                  err
);

  import aes_pkg::*;

  if (AES_LEN != WORDS_PER_BLK * WORD_W) begin : g_bad_len
    $error("aes_word_bridge: AES_LEN must equal 4*WORD_W");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("aes_word_bridge: TIMEOUT_CYCLES must be at least 1");
  end

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q;
  logic [AES_LEN-1:0]   res_q;
  logic [AES_LEN-1:0]   pt_q;
  logic [ADDR_WIDTH-1:0] key_q;
  logic                 accept, xfer, capture, last_word;
  logic                 in_ready_c, out_valid_c;
  logic                 timeout_hit;

  assign last_word = (cnt_q == CNT_W'(WORDS_PER_BLK - 1));

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= FILL;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    aes_start   = 1'b0;
    busy        = 1'b1;
    accept      = 1'b0;
    xfer        = 1'b0;
    capture     = 1'b0;
    case (state_q)
      FILL: begin
        busy       = 1'b0;
        in_ready_c = 1'b1;
        accept     = bus.in_valid;
        if (accept && last_word) state_d = START;
      end
      START: begin
        aes_start = 1'b1;
        state_d   = WAIT;
      end
      WAIT: begin
        // done in the same cycle as the watchdog expiry takes priority
        if (aes_done) begin
          capture = 1'b1;
          state_d = DRAIN;
        end else if (timeout_hit) begin
          state_d = FILL;
        end
      end
      DRAIN: begin
        out_valid_c = 1'b1;
        xfer        = bus.out_ready;
        if (xfer && last_word) state_d = FILL;
      end
      default: state_d = FILL;
    endcase
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.out_data  = res_q[AES_LEN-1 -: WORD_W];
  assign aes_plaintext = pt_q;
  assign aes_key_addr  = key_q;

  // Result drains MSW first by shifting the capture register left one word per transfer.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cnt_q <= '0;
      pt_q  <= '0;
      key_q <= '0;
      res_q <= '0;
    end else begin
      if (accept) begin
        for (int unsigned k = 0; k < WORDS_PER_BLK; k++) begin
          if (cnt_q == CNT_W'(k)) pt_q[AES_LEN-1-WORD_W*k -: WORD_W] <= bus.in_data;
        end
        if (cnt_q == '0) key_q <= bus.in_key_addr;
        cnt_q <= cnt_q + 1'b1;
      end
      if (capture) begin
        res_q <= aes_result;
        cnt_q <= '0;
      end
      if (xfer) begin
        res_q <= res_q << WORD_W;
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

`ifdef AES_BRIDGE_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] tcnt_q;
  logic          err_q;

  assign timeout_hit = (tcnt_q == TW'(TIMEOUT_CYCLES - 1));
  assign err         = err_q;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      tcnt_q <= '0;
      err_q  <= 1'b0;
    end else begin
      if (state_q == START) begin
        tcnt_q <= '0;
      end else if (state_q == WAIT) begin
        tcnt_q <= tcnt_q + 1'b1;
      end
      if (state_q == WAIT && !aes_done && timeout_hit) err_q <= 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign err         = 1'b0;
`endif

endmodule

// File: tb/tb_aes_word_bridge.sv
// Directed self-checking bench for aes_word_bridge with a result scoreboard queue.
// Timeout scenarios run only when AES_BRIDGE_TIMEOUT_EN is defined.
module tb_aes_word_bridge;

  localparam int unsigned AES_LEN        = 128;
  localparam int unsigned WORD_W         = 32;
  localparam int unsigned ADDR_WIDTH     = 5;
  localparam int unsigned TIMEOUT_CYCLES = 64;

  logic                  clk = 1'b0;
  logic                  nrst;
  logic                  aes_start;
  logic [ADDR_WIDTH-1:0] aes_key_addr;
  logic [AES_LEN-1:0]    aes_plaintext;
  logic [AES_LEN-1:0]    aes_result;
  logic                  aes_done;
  logic                  busy;
  logic                  err;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  logic [WORD_W-1:0] exp_q[$];

  always #5 clk = ~clk;

  aes_word_bridge_if #(.WORD_W(WORD_W), .ADDR_WIDTH(ADDR_WIDTH)) bus ();

  aes_word_bridge #(
    .AES_LEN       (AES_LEN),
    .WORD_W        (WORD_W),
    .ADDR_WIDTH    (ADDR_WIDTH),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clk          (clk),
    .nrst         (nrst),
    .bus          (bus),
    .aes_start    (aes_start),
    .aes_key_addr (aes_key_addr),
    .aes_plaintext(aes_plaintext),
    .aes_result   (aes_result),
    .aes_done     (aes_done),
    .busy         (busy),
    .err          (err)
  );

  task automatic chk(input string tag, input logic [AES_LEN-1:0] obs, input logic [AES_LEN-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic bound_fail(input string tag);
    n_cmp++;
    n_bad++;
    $error("FAIL %s observed=no-event expected=event-within-bound", tag);
  endtask

  task automatic send_word(input logic [WORD_W-1:0] d, input logic [ADDR_WIDTH-1:0] key, input int gap);
    int n;
    @(negedge clk);
    bus.in_valid    = 1'b1;
    bus.in_data     = d;
    bus.in_key_addr = key;
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) bound_fail("in_ready_wait");
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (gap) @(posedge clk);
  endtask

  // Called #1 after the 4th accept: START cycle, then one cycle into WAIT.
  task automatic check_block(input logic [AES_LEN-1:0] pt, input logic [ADDR_WIDTH-1:0] key);
    chk("start_high", aes_start, 1'b1);
    chk("plaintext", aes_plaintext, pt);
    chk("key_addr", aes_key_addr, key);
    @(posedge clk);
    #1;
    chk("start_one_cycle", aes_start, 1'b0);
    chk("busy_wait", busy, 1'b1);
  endtask

  task automatic send_block(input logic [AES_LEN-1:0] pt, input logic [ADDR_WIDTH-1:0] key, input int gap);
    for (int i = 0; i < 4; i++) begin
      logic [ADDR_WIDTH-1:0] k;
      k = (i == 0) ? key : key + ADDR_WIDTH'(i + 1);
      send_word(pt[AES_LEN-1-WORD_W*i -: WORD_W], k, (i == 3) ? 0 : gap);
    end
    check_block(pt, key);
  endtask

  task automatic done_pulse(input logic [AES_LEN-1:0] r, input bit expect_capture);
    @(negedge clk);
    aes_result = r;
    aes_done   = 1'b1;
    if (expect_capture)
      for (int i = 0; i < 4; i++) exp_q.push_back(r[AES_LEN-1-WORD_W*i -: WORD_W]);
    @(posedge clk);
    #1;
    aes_done = 1'b0;
  endtask

  task automatic drain(input int stall_idx, input int stall_len);
    logic [WORD_W-1:0] e;
    int n;
    for (int w = 0; w < 4; w++) begin
      @(negedge clk);
      n = 0;
      while (bus.out_valid !== 1'b1 && n < 200) begin
        @(negedge clk);
        n++;
      end
      if (n >= 200) bound_fail("out_valid_wait");
      if (exp_q.size() == 0) begin
        bound_fail("scoreboard_empty");
        e = '0;
      end else begin
        e = exp_q.pop_front();
      end
      chk("out_data", bus.out_data, e);
      if (w == stall_idx) begin
        repeat (stall_len) begin
          @(negedge clk);
          chk("stall_valid", bus.out_valid, 1'b1);
          chk("stall_data", bus.out_data, e);
        end
      end
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
    end
    chk("drain_end_valid", bus.out_valid, 1'b0);
    chk("drain_end_ready", bus.in_ready, 1'b1);
    chk("drain_end_busy", busy, 1'b0);
    chk("scoreboard_left", exp_q.size(), 0);
  endtask

  task automatic check_reset_values();
    chk("rst_in_ready", bus.in_ready, 1'b1);
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_start", aes_start, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_plaintext", aes_plaintext, '0);
    chk("rst_key_addr", aes_key_addr, '0);
    chk("rst_out_data", bus.out_data, '0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=still-running expected=finished");
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    logic [AES_LEN-1:0] pt_a, res_a, pt_b, res_b, pt_c;
    pt_a  = 128'h00112233_44556677_8899aabb_ccddeeff;
    res_a = 128'h69c4e0d8_6a7b0430_d8cdb780_70b4c55a;
    pt_b  = 128'hdeadbeef_01234567_89abcdef_a5a55a5a;
    res_b = 128'h0f1e2d3c_4b5a6978_8796a5b4_c3d2e1f0;
    pt_c  = 128'h11111111_22222222_33333333_44444444;

    nrst            = 1'b0;
    bus.in_valid    = 1'b0;
    bus.in_data     = '0;
    bus.in_key_addr = '0;
    bus.out_ready   = 1'b0;
    aes_done        = 1'b0;
    aes_result      = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values();
    @(negedge clk);
    nrst = 1'b1;

    // basic round trip
    send_block(pt_a, 5'd3, 0);
    done_pulse(res_a, 1'b1);
    chk("first_valid_after_done", bus.out_valid, 1'b1);
    drain(-1, 0);

    // output backpressure on word 1
    send_block(pt_a, 5'd3, 0);
    done_pulse(res_a, 1'b1);
    drain(1, 5);

    // input gaps, then in_valid while waiting is not consumed
    send_block(pt_b, 5'd7, 3);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = 32'hcafef00d;
    repeat (4) begin
      @(negedge clk);
      chk("wait_in_ready", bus.in_ready, 1'b0);
    end
    chk("wait_pt_hold", aes_plaintext, pt_b);
    bus.in_valid = 1'b0;
    done_pulse(res_b, 1'b1);
    chk("hold_pt_drain", aes_plaintext, pt_b);
    chk("hold_key_drain", aes_key_addr, 5'd7);
    drain(2, 2);

    // reset mid-operation, late done ignored
    send_block(pt_c, 5'd12, 0);
    @(negedge clk);
    nrst = 1'b0;
    #1;
    check_reset_values();
    @(negedge clk);
    nrst = 1'b1;
    done_pulse(res_a, 1'b0);
    @(posedge clk);
    #1;
    chk("late_done_valid", bus.out_valid, 1'b0);
    chk("late_done_busy", busy, 1'b0);
    send_block(pt_c, 5'd12, 1);
    done_pulse(res_b, 1'b1);
    drain(-1, 0);

    // spurious done after two words
    send_word(pt_a[127:96], 5'd21, 0);
    send_word(pt_a[95:64], 5'd0, 0);
    done_pulse(res_b, 1'b0);
    chk("spurious_busy", busy, 1'b0);
    chk("spurious_valid", bus.out_valid, 1'b0);
    chk("spurious_ready", bus.in_ready, 1'b1);
    send_word(pt_a[63:32], 5'd0, 0);
    send_word(pt_a[31:0], 5'd0, 0);
    check_block(pt_a, 5'd21);
    done_pulse(res_a, 1'b1);
    drain(0, 1);

`ifdef AES_BRIDGE_TIMEOUT_EN
    // done on the last permitted WAIT cycle wins over the timeout
    send_block(pt_b, 5'd9, 0);
    repeat (TIMEOUT_CYCLES - 1) @(posedge clk);
    #1;
    chk("to_edge_busy", busy, 1'b1);
    chk("to_edge_err", err, 1'b0);
    done_pulse(res_b, 1'b1);
    chk("to_edge_err_after", err, 1'b0);
    drain(-1, 0);

    // no done at all: timeout sets err and returns to FILL
    send_block(pt_c, 5'd1, 0);
    repeat (TIMEOUT_CYCLES - 1) @(posedge clk);
    #1;
    chk("to_pre_busy", busy, 1'b1);
    chk("to_pre_err", err, 1'b0);
    @(posedge clk);
    #1;
    chk("to_err", err, 1'b1);
    chk("to_busy", busy, 1'b0);
    chk("to_valid", bus.out_valid, 1'b0);
    chk("to_ready", bus.in_ready, 1'b1);
    done_pulse(res_a, 1'b0);
    @(posedge clk);
    #1;
    chk("to_late_valid", bus.out_valid, 1'b0);
    send_block(pt_a, 5'd4, 0);
    done_pulse(res_a, 1'b1);
    drain(-1, 0);
    chk("to_err_sticky", err, 1'b1);
    @(negedge clk);
    nrst = 1'b0;
    #1;
    chk("to_err_cleared", err, 1'b0);
    @(negedge clk);
    nrst = 1'b1;
`else
    // without the watchdog WAIT is held indefinitely
    send_block(pt_b, 5'd9, 0);
    repeat (100) @(posedge clk);
    #1;
    chk("hold_busy", busy, 1'b1);
    chk("hold_valid", bus.out_valid, 1'b0);
    chk("hold_err", err, 1'b0);
    done_pulse(res_b, 1'b1);
    drain(-1, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/aes_word_bridge.md
Name: aes_word_bridge

Overview:
- Word-serial front/back end for top_aes: packs four 32-bit input words into the 128-bit plaintext and issues a one-cycle start.
- Waits for done, captures the 128-bit result, then streams it out as four 32-bit words on a valid/ready interface.
- Sits between the core's 32-bit datapath/bus and top_aes; exactly one block in flight at a time.

Parameters:
- AES_LEN, 128, block width; must equal 4*WORD_W.
- WORD_W, 32, input/output word width.
- ADDR_WIDTH, 5, key ROM address width forwarded to top_aes.
- TIMEOUT_CYCLES, 64, watchdog limit in WAIT; used only with AES_BRIDGE_TIMEOUT_EN.

Ports:
- clk  in  1  system clock, rising edge.
- nrst  in  1  asynchronous active-low reset.
- in_valid  in  1  input word valid.
- in_ready  out  1  bridge accepts a word; high only in FILL.
- in_data  in  WORD_W  plaintext word.
- in_key_addr  in  ADDR_WIDTH  key ROM address; sampled with the first word of a block.
- out_valid  out  1  result word valid.
- out_ready  in  1  consumer accepts the result word.
- out_data  out  WORD_W  result word.
- aes_start  out  1  one-cycle start pulse to top_aes.
- aes_key_addr  out  ADDR_WIDTH  registered key address to top_aes.
- aes_plaintext  out  AES_LEN  registered packed plaintext.
- aes_result  in  AES_LEN  top_aes result.
- aes_done  in  1  top_aes done pulse.
- busy  out  1  high in any state other than FILL.
- err  out  1  sticky timeout flag; constant 0 without AES_BRIDGE_TIMEOUT_EN.

Behaviour:
- Reset (async, nrst=0):
  - state=FILL, word counter=0.
  - in_ready=1, out_valid=0, aes_start=0, busy=0, err=0.
  - aes_plaintext=0, aes_key_addr=0, out_data=0.
- FSM states: FILL, START, WAIT, DRAIN.
- FILL:
  - A word is accepted on in_valid && in_ready.
  - Word k (k=0..3) is written to aes_plaintext[127-32k -: 32]; word 0 is the MSW.
  - in_key_addr is latched on acceptance of word 0 only.
  - On acceptance of word 3: counter returns to 0, next state START.
  - Partial fill persists indefinitely; no timeout in FILL.
- START:
  - aes_start=1 for exactly this one cycle; in_ready=0.
  - Next state WAIT, unconditionally.
- WAIT:
  - On aes_done=1: latch aes_result into the output shift register, counter=0, next state DRAIN.
  - aes_done in any other state is ignored.
- DRAIN:
  - out_valid=1; out_data = result word for the current counter, MSW first.
  - A transfer occurs on out_valid && out_ready; the counter then increments.
  - out_data stays stable while out_ready=0.
  - After the 4th transfer: out_valid=0 next cycle, state FILL, in_ready=1.
  - No back-to-back overlap: new input is accepted only after the drain completes.
- Latency:
  - Cycle after the 4th input accept: aes_start is high.
  - First out_valid comes 1 cycle after the aes_done cycle.
- aes_plaintext and aes_key_addr hold their values from START through DRAIN; the next FILL overwrites them word by word.
- in_valid with in_ready=0 is not consumed; the upstream must hold it.
- Reset mid-operation: return to the reset values immediately. A result arriving afterwards is ignored because the bridge is in FILL.

Optional Feature:
- Macro: AES_BRIDGE_TIMEOUT_EN.
- With the macro:
  - A counter clears on entry to WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT_CYCLES with no aes_done: set err=1 (sticky until nrst), discard the block, go to FILL, counter=0.
  - aes_done in the same cycle as the timeout wins: normal capture, err unchanged.
- Without the macro: no counter; WAIT is held indefinitely; err tied to 0.

Decomposition:
- Shared package aes_pkg:
  - localparams AES_LEN=128, WORD_W=32, WORDS_PER_BLK=4.
  - State encoding: FILL=2'd0, START=2'd1, WAIT=2'd2, DRAIN=2'd3.
- No sub-module; a single FSM with the pack/unpack registers. Instantiated beside top_aes by the integrating level.

Test Plan:
- Basic round trip:
  - Write 00112233, 44556677, 8899aabb, ccddeeff with key_addr=5'd3.
  - Required: aes_plaintext=00112233_44556677_8899aabb_ccddeeff, aes_key_addr=3, aes_start high exactly one cycle after the 4th accept.
  - Stub drives aes_done with result 69c4e0d8_6a7b0430_d8cdb780_70b4c55a.
  - Required out_data sequence: 69c4e0d8, 6a7b0430, d8cdb780, 70b4c55a.
- Output backpressure: hold out_ready=0 for 5 cycles on word 1 -> out_data stays 6a7b0430 with out_valid=1; no word is skipped or duplicated.
- Input gap and blocking:
  - Gaps of 3 idle cycles between input words -> packing is unaffected.
  - in_valid asserted during WAIT -> in_ready=0 and nothing is accepted.
- Reset mid-operation:
  - Assert nrst low in WAIT -> all outputs at reset values.
  - A later aes_done is ignored; the next 4 words process normally.
- Spurious done: aes_done pulse in FILL after 2 words -> no state change; the fill completes correctly.
- Timeout (macro on, TIMEOUT_CYCLES=64):
  - No aes_done -> err=1 after 64 WAIT cycles, state FILL, no out_valid.
  - Done on exactly cycle 64 -> normal drain, err=0.
